// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR coefficient SRAM controller
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  localparam int DEF_SRAM_DEPTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  // Registered read latency of the coefficient SRAM (address to data register).
  localparam int RD_LAT = 1;

endpackage

// File: rtl/fir_rd_align.sv
// rtl/fir_rd_align.sv - delays read strobe and address so valid/index line up with SRAM data
module fir_rd_align
  import fir_pkg::*;
#(
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STAGES     = RD_LAT + 1
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iRdStb,
  input  logic [ADDR_WIDTH-1:0] iRdAddr,
  output logic                  oValid,
  output logic [ADDR_WIDTH-1:0] oIdx,
  output logic                  oLast
);

  logic [STAGES-1:0]     vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] idx_q [STAGES];
  logic [ADDR_WIDTH-1:0] idx_d [STAGES];

  // Shift the strobe and its address down the pipe one stage per clock.
  always_comb begin
    vld_d[0] = iRdStb;
    idx_d[0] = iRdAddr;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  // Pipe registers; reset empties the pipe so no stale coefficient is reported.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) idx_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) idx_q[i] <= idx_d[i];
    end
  end

  assign oValid = vld_q[STAGES-1];
  assign oIdx   = idx_q[STAGES-1];
  assign oLast  = vld_q[STAGES-1] && (idx_q[STAGES-1] == ADDR_WIDTH'(SRAM_DEPTH - 1));

endmodule

// File: rtl/fir_coeff_sram_ctrl.sv
// rtl/fir_coeff_sram_ctrl.sv - single-port coefficient SRAM load/sweep controller (option: FIR_CTRL_OVERRUN_CNT_EN)
module fir_coeff_sram_ctrl
  import fir_pkg::*;
#(
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iCoeffUpdateFlag,
  input  logic                  iCoeffValid,
  input  logic [DATA_WIDTH-1:0] iCoeffData,
  output logic                  oCoeffReady,
  input  logic                  iEnSample,
  output logic                  oCsn,
  output logic                  oWrn,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oWrDt,
  input  logic [DATA_WIDTH-1:0] iRdDt,
  output logic [DATA_WIDTH-1:0] oCoeff,
  output logic                  oCoeffValid,
  output logic [ADDR_WIDTH-1:0] oCoeffIdx,
  output logic                  oSweepDone,
  output logic                  oLoadDone,
  output logic                  oBusy
`ifdef FIR_CTRL_OVERRUN_CNT_EN
  ,
  output logic [7:0]            oOverrunCnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  fir_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  csn_q, csn_d;
  logic                  wrn_q, wrn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdt_q, wrdt_d;
  logic                  load_done_q, load_done_d;

  // Next-state and next SRAM strobe; one strobe per cycle at most, so write and read never overlap.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    csn_d       = 1'b1;
    wrn_d       = 1'b1;
    addr_d      = addr_q;
    wrdt_d      = wrdt_q;
    load_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iCoeffUpdateFlag) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else if (iEnSample) begin
          state_d  = ST_SWEEP;
          rd_ptr_d = '0;
        end
      end
      ST_LOAD: begin
        if (iCoeffValid) begin
          csn_d  = 1'b0;
          wrn_d  = 1'b0;
          addr_d = wr_ptr_q;
          wrdt_d = iCoeffData;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d    = '0;
            load_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        if (!iCoeffUpdateFlag) state_d = ST_IDLE;
      end
      ST_SWEEP: begin
        csn_d  = 1'b0;
        wrn_d  = 1'b1;
        addr_d = rd_ptr_q;
        if (rd_ptr_q == LAST_ADDR) begin
          rd_ptr_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (iCoeffUpdateFlag) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointers and registered SRAM pins; reset drops any strobe immediately.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      csn_q       <= 1'b1;
      wrn_q       <= 1'b1;
      addr_q      <= '0;
      wrdt_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      csn_q       <= csn_d;
      wrn_q       <= wrn_d;
      addr_q      <= addr_d;
      wrdt_q      <= wrdt_d;
      load_done_q <= load_done_d;
    end
  end

  assign oCsn        = csn_q;
  assign oWrn        = wrn_q;
  assign oAddr       = addr_q;
  assign oWrDt       = wrdt_q;
  assign oLoadDone   = load_done_q;
  assign oCoeffReady = (state_q == ST_LOAD);
  assign oBusy       = (state_q != ST_IDLE);
  assign oCoeff      = iRdDt;

  fir_rd_align #(
    .SRAM_DEPTH (SRAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_align (
    .iClk    (iClk),
    .iRsn    (iRsn),
    .iRdStb  (~csn_q & wrn_q),
    .iRdAddr (addr_q),
    .oValid  (oCoeffValid),
    .oIdx    (oCoeffIdx),
    .oLast   (oSweepDone)
  );

`ifdef FIR_CTRL_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  // Count sample strobes that arrive while busy; restart the count on each fresh load.
  always_comb begin
    ovr_d = ovr_q;
    if (state_q == ST_IDLE && iCoeffUpdateFlag) begin
      ovr_d = '0;
    end else if (iEnSample && state_q != ST_IDLE && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // Overrun counter register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) ovr_q <= '0;
    else       ovr_q <= ovr_d;
  end

  assign oOverrunCnt = ovr_q;
`endif

endmodule

// File: tb/tb_fir_coeff_sram_ctrl.sv
// tb/tb_fir_coeff_sram_ctrl.sv - directed self-checking bench for fir_coeff_sram_ctrl
module tb_fir_coeff_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag, cvalid, en_sample;
  logic [15:0] cdata;
  logic        ready, csn, wrn, cvld, sdone, ldone, busy;
  logic [3:0]  addr, cidx;
  logic [15:0] wrdt, rddt, coeff;
`ifdef FIR_CTRL_OVERRUN_CNT_EN
  logic [7:0]  ovr;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_coeff_sram_ctrl dut (
    .iClk             (clk),
    .iRsn             (rst_n),
    .iCoeffUpdateFlag (flag),
    .iCoeffValid      (cvalid),
    .iCoeffData       (cdata),
    .oCoeffReady      (ready),
    .iEnSample        (en_sample),
    .oCsn             (csn),
    .oWrn             (wrn),
    .oAddr            (addr),
    .oWrDt            (wrdt),
    .iRdDt            (rddt),
    .oCoeff           (coeff),
    .oCoeffValid      (cvld),
    .oCoeffIdx        (cidx),
    .oSweepDone       (sdone),
    .oLoadDone        (ldone),
    .oBusy            (busy)
`ifdef FIR_CTRL_OVERRUN_CNT_EN
    ,
    .oOverrunCnt      (ovr)
`endif
  );

  // SRAM model: address registered at the first edge, data register at the second.
  logic [15:0] mem [16];
  logic [15:0] rd_s1;
  always @(posedge clk) begin
    if (!csn && !wrn) mem[addr] <= wrdt;
    if (!csn && wrn)  rd_s1 <= mem[addr];
    rddt <= rd_s1;
  end

  // Event logs of what the pins did, indexed by cycle number.
  int cyc = 0;
  int wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$], v_idx[$], v_coef[$], v_c[$];
  int sd_n = 0, sd_idx = 0, ld_n = 0, ld_addr = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!csn && !wrn) begin wr_a.push_back(int'(addr)); wr_d.push_back(int'(wrdt)); wr_c.push_back(cyc); end
    if (!csn && wrn)  begin rd_a.push_back(int'(addr)); rd_c.push_back(cyc); end
    if (cvld) begin v_idx.push_back(int'(cidx)); v_coef.push_back(int'(coeff)); v_c.push_back(cyc); end
    if (sdone) begin sd_n <= sd_n + 1; sd_idx <= int'(cidx); end
    if (ldone) begin ld_n <= ld_n + 1; ld_addr <= int'(addr); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_mem [16];
  int wb, rb, vb, sdb, ldb;

  task automatic snap();
    wb = wr_a.size(); rb = rd_a.size(); vb = v_idx.size(); sdb = sd_n; ldb = ld_n;
  endtask

  // Verify the sweep recorded since the last snapshot against exp_mem.
  task automatic check_sweep(input string pfx);
    int bad_rd, bad_v;
    bad_rd = 0; bad_v = 0;
    chk({pfx, "_rd_cnt"}, rd_a.size() - rb, 16);
    chk({pfx, "_v_cnt"}, v_idx.size() - vb, 16);
    if (rd_a.size() - rb == 16 && v_idx.size() - vb == 16) begin
      for (int k = 0; k < 16; k++) begin
        if (rd_a[rb+k] != k || rd_c[rb+k] != rd_c[rb] + k) bad_rd++;
        if (v_idx[vb+k] != k || v_c[vb+k] != rd_c[rb] + 2 + k ||
            v_coef[vb+k] != int'(exp_mem[k])) bad_v++;
      end
    end
    chk({pfx, "_rd_seq_bad"}, bad_rd, 0);
    chk({pfx, "_v_seq_bad"}, bad_v, 0);
    chk({pfx, "_done_cnt"}, sd_n - sdb, 1);
    chk({pfx, "_done_idx"}, sd_idx, 15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, found;
    rst_n = 1'b0; flag = 1'b0; cvalid = 1'b0; en_sample = 1'b0; cdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_csn", csn, 1);
    chk("rst_wrn", wrn, 1);
    chk("rst_addr_wrdt", {addr, wrdt}, 0);
    chk("rst_ready_busy", {ready, busy}, 0);
    chk("rst_vld_idx_done", {cvld, cidx, sdone, ldone}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full back-to-back load of 0x0001..0x0010.
    snap();
    flag = 1'b1;
    @(negedge clk);
    chk("load_ready", ready, 1);
    for (int i = 0; i < 16; i++) begin
      cvalid = 1'b1; cdata = 16'(i + 1); exp_mem[i] = 16'(i + 1);
      @(negedge clk);
    end
    cvalid = 1'b0;
    repeat (2) @(negedge clk);
    flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("load_wr_cnt", wr_a.size() - wb, 16);
    bad = 0;
    if (wr_a.size() - wb == 16)
      for (int k = 0; k < 16; k++)
        if (wr_a[wb+k] != k || wr_d[wb+k] != k + 1 || wr_c[wb+k] != wr_c[wb] + k) bad++;
    chk("load_wr_seq_bad", bad, 0);
    chk("load_done_cnt", ld_n - ldb, 1);
    chk("load_done_addr", ld_addr, 15);
    chk("load_idle_busy", busy, 0);
    bad = 0;
    for (int k = 0; k < 16; k++) if (mem[k] !== exp_mem[k]) bad++;
    chk("load_mem_bad", bad, 0);

    // Sweep after the load.
    snap();
    en_sample = 1'b1; @(negedge clk); en_sample = 1'b0;
    repeat (24) @(negedge clk);
    check_sweep("sweep1");
    chk("sweep1_idle", busy, 0);

    // Load with gaps, abandoned after 7 words.
    snap();
    flag = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      cvalid = (k % 2 == 0);
      cdata  = 16'h0100 + 16'(k / 2);
      if (k % 2 == 0) exp_mem[k/2] = 16'h0100 + 16'(k / 2);
      @(negedge clk);
    end
    cvalid = 1'b0;
    @(negedge clk);
    flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("gap_wr_cnt", wr_a.size() - wb, 7);
    bad = 0;
    if (wr_a.size() - wb == 7)
      for (int k = 0; k < 7; k++)
        if (wr_a[wb+k] != k || wr_d[wb+k] != 32'h100 + k || wr_c[wb+k] != wr_c[wb] + 2 * k) bad++;
    chk("gap_wr_seq_bad", bad, 0);
    chk("gap_no_done", ld_n - ldb, 0);
    chk("gap_idle_busy", busy, 0);

    // Next load restarts at address 0.
    snap();
    flag = 1'b1;
    @(negedge clk);
    cvalid = 1'b1; cdata = 16'hABCD; exp_mem[0] = 16'hABCD;
    @(negedge clk);
    cvalid = 1'b0;
    repeat (2) @(negedge clk);
    flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("reload_wr_cnt", wr_a.size() - wb, 1);
    if (wr_a.size() - wb == 1) chk("reload_addr_data", {wr_a[wb][3:0], wr_d[wb][15:0]}, {4'd0, 16'hABCD});

    // Collision: extra sample at sweep cycle 3, flag rising at cycle 8.
    snap();
    en_sample = 1'b1; @(negedge clk); en_sample = 1'b0;
    repeat (2) @(negedge clk);
    en_sample = 1'b1; @(negedge clk); en_sample = 1'b0;
    repeat (4) @(negedge clk);
    flag = 1'b1;
    repeat (20) @(negedge clk);
    check_sweep("coll");
    chk("coll_no_wr", wr_a.size() - wb, 0);
    chk("coll_load_ready", {busy, ready}, 2'b11);
`ifdef FIR_CTRL_OVERRUN_CNT_EN
    chk("coll_overrun", ovr, 1);
`endif
    flag = 1'b0;
    repeat (3) @(negedge clk);

    // Priority: flag and sample in the same idle cycle.
    snap();
    flag = 1'b1; en_sample = 1'b1;
    @(negedge clk);
    en_sample = 1'b0;
    repeat (20) @(negedge clk);
    chk("prio_no_rd", rd_a.size() - rb, 0);
    chk("prio_ready", ready, 1);
    flag = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while the read strobe for address 5 is on the pins.
    en_sample = 1'b1; @(negedge clk); en_sample = 1'b0;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      if (!csn && wrn && addr == 4'd5) found = 1;
      else @(negedge clk);
    end
    chk("rst_found_addr5", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_csn", csn, 1);
    chk("rst_mid_vld_busy", {cvld, busy}, 0);
    snap();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_rd", rd_a.size() - rb, 0);
    chk("rst_no_vld", v_idx.size() - vb, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_coeff_sram_ctrl.md
Name: fir_coeff_sram_ctrl

Overview:
- Access controller that sits directly in front of the FIR coefficient single-port SRAM.
- Loads coefficients from a host valid/ready stream into the SRAM during update mode.
- On each input sample strobe, sweeps all SRAM addresses in read mode and streams the coefficients, with index, to the downstream MAC.
- Handles the SRAM's 1-cycle registered read latency and the write/read arbitration of a single port.

Parameters:
- SRAM_DEPTH, 16, number of coefficient taps (SRAM words).
- DATA_WIDTH, 16, coefficient width in bits.
- ADDR_WIDTH, 4, SRAM address width; must equal ceil(log2(SRAM_DEPTH)).

Ports:
- iClk  in  1  rising-edge clock
- iRsn  in  1  reset, asynchronous, active-low
- iCoeffUpdateFlag  in  1  1 = update (load) mode requested, 0 = run mode
- iCoeffValid  in  1  host coefficient valid
- iCoeffData  in  DATA_WIDTH  host coefficient
- oCoeffReady  out  1  controller accepts iCoeffData
- iEnSample  in  1  one-cycle pulse: new sample, start a coefficient sweep
- oCsn  out  1  SRAM chip select, active-low
- oWrn  out  1  SRAM 0 = write, 1 = read
- oAddr  out  ADDR_WIDTH  SRAM address
- oWrDt  out  DATA_WIDTH  SRAM write data
- iRdDt  in  DATA_WIDTH  SRAM read data (registered inside SRAM)
- oCoeff  out  DATA_WIDTH  coefficient to MAC
- oCoeffValid  out  1  oCoeff/oCoeffIdx valid
- oCoeffIdx  out  ADDR_WIDTH  tap index of oCoeff
- oSweepDone  out  1  one-cycle pulse, coincident with the last valid coefficient
- oLoadDone  out  1  one-cycle pulse, asserted after the SRAM_DEPTH-th accepted coefficient
- oBusy  out  1  state != IDLE

Behaviour:
- Reset (iRsn low, async): state IDLE. Outputs: oCsn=1, oWrn=1, oAddr=0, oWrDt=0, oCoeffReady=0, oCoeffValid=0, oCoeffIdx=0, oSweepDone=0, oLoadDone=0, oBusy=0. Pointers cleared. Reset mid-load or mid-sweep aborts with no further SRAM strobes.
- Registering: all SRAM-side outputs are registered.
- oCoeff: combinational pass-through of iRdDt.
- FSM states: IDLE, LOAD, SWEEP, DRAIN.
- IDLE:
  - iCoeffUpdateFlag=1 -> LOAD; wrPtr=0.
  - Else iEnSample=1 -> SWEEP; rdPtr=0.
  - Update flag has priority over iEnSample in the same cycle; that iEnSample is dropped.
- LOAD:
  - oCoeffReady=1.
  - Each cycle with iCoeffValid & oCoeffReady, the next clock drives oCsn=0, oWrn=0, oAddr=wrPtr, oWrDt=iCoeffData; wrPtr then increments.
  - Cycles without a handshake drive oCsn=1.
  - When wrPtr = SRAM_DEPTH-1 is written: wrPtr wraps to 0, oLoadDone pulses one cycle after that handshake, and the FSM stays in LOAD while the flag is high.
  - iCoeffUpdateFlag falling -> IDLE next cycle, oCoeffReady=0. A partial load is kept; the next LOAD restarts at address 0.
  - iEnSample in LOAD is ignored.
- SWEEP:
  - Drives oCsn=0, oWrn=1, oAddr=rdPtr for SRAM_DEPTH consecutive cycles, addresses 0..SRAM_DEPTH-1.
  - After address SRAM_DEPTH-1 -> DRAIN.
- DRAIN: oCsn=1 for one cycle, then -> IDLE, or -> LOAD if iCoeffUpdateFlag=1.
- Read latency: for the read strobe presented in cycle N, oCoeffValid=1 and oCoeffIdx=that address in cycle N+2 (SRAM captures at edge N+1).
  - oCoeffValid is a delayed copy of the read strobe; oCoeffIdx is a delayed copy of oAddr.
  - Result: SRAM_DEPTH contiguous valid cycles; oSweepDone pulses with index SRAM_DEPTH-1.
- Boundary conditions:
  - iEnSample while SWEEP or DRAIN: dropped, never queued.
  - iCoeffUpdateFlag rising mid-sweep: the sweep completes, then LOAD.
  - The SRAM never sees write and read strobes in the same cycle.

Optional Feature:
- Macro: FIR_CTRL_OVERRUN_CNT_EN.
- Defined: adds port oOverrunCnt, out, 8 bits. It is a saturating counter (stops at 255) of iEnSample pulses dropped while SWEEP, DRAIN or LOAD. It resets to 0 asynchronously and clears on IDLE->LOAD.
- Undefined: port absent; dropped pulses are silent.

Decomposition:
- Shared package fir_pkg:
  - state encoding (IDLE=2'd0, LOAD=2'd1, SWEEP=2'd2, DRAIN=2'd3);
  - default SRAM_DEPTH/DATA_WIDTH;
  - read-latency constant RD_LAT=1.
- One natural sub-module: fir_rd_align, the 2-stage valid/index delay pipe that aligns oCoeffValid/oCoeffIdx/oSweepDone to SRAM data.
- FSM and pointers stay in the top.

Test Plan:
- Reset: assert iRsn low mid-sweep at address 5 -> same cycle oCsn=1, oCoeffValid=0, oBusy=0; no further SRAM strobes.
- Load: flag=1, stream 0x0001..0x0010 back-to-back -> 16 writes at addr 0..15, oLoadDone single pulse after the 16th; SRAM contents match.
- Load with gaps: iCoeffValid toggles 1010… -> writes occur only on handshake cycles, addresses contiguous; drop flag after 7 words -> IDLE, next load restarts at addr 0.
- Sweep: after load, iEnSample pulse -> reads addr 0..15 on 16 consecutive cycles; oCoeffValid 16 cycles starting 2 cycles after the first strobe; oCoeff=0x0001..0x0010, oCoeffIdx=0..15; oSweepDone with idx 15.
- Collision: iEnSample at sweep cycle 3, and flag rising at cycle 8 -> sweep unaffected, extra pulse dropped (oOverrunCnt=1 if enabled), LOAD entered after DRAIN.
- Priority: flag=1 and iEnSample in the same IDLE cycle -> LOAD entered, no read strobes issued.
